vp_frame_ctrl: RTL

//  Frame-level controller for the vp video-processing pipeline. Sits on the de/hs/vs stream

---
 rtl/vp_frame_pkg.sv | 27 ++
 rtl/vp_edge_det.sv | 20 ++
 rtl/vp_frame_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vp_frame_pkg.sv
// Shared constants and types for the vp frame controller: default widths,
// processing-mode encodings and mode-handshake FSM states.
package vp_frame_pkg;

    localparam int X_W_DEF    = 11;
    localparam int Y_W_DEF    = 11;
    localparam int MODE_W_DEF = 2;
    localparam int LOCK_W     = 4;

    typedef enum logic [MODE_W_DEF-1:0] {
        MODE_BYPASS = 2'd0,
        MODE_GRAY   = 2'd1,
        MODE_BIN    = 2'd2,
        MODE_EDGE   = 2'd3
    } vp_mode_e;

    typedef enum logic {
        MST_IDLE = 1'b0,
        MST_PEND = 1'b1
    } mode_st_e;

    function automatic logic [LOCK_W-1:0] sat_inc(input logic [LOCK_W-1:0] v,
                                                  input logic [LOCK_W-1:0] lim);
        return (v >= lim) ? lim : v + LOCK_W'(1);
    endfunction

endpackage

// File: rtl/vp_edge_det.sv
// Registered single-bit edge detector; q is the input delayed one cycle and
// edge_p flags a rising (FALL=0) or falling (FALL=1) transition of d.
module vp_edge_det #(
    parameter bit FALL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic edge_p
);

    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end

    assign edge_p = FALL ? (~d & q) : (d & ~q);

endmodule

// File: rtl/vp_frame_ctrl.sv
// vp frame controller: pixel coordinates, per-frame resolution measurement,
// lock detection and frame-aligned processing-mode switching.
module vp_frame_ctrl
    import vp_frame_pkg::*;
#(
    parameter int X_W         = X_W_DEF,
    parameter int Y_W         = Y_W_DEF,
    parameter int MODE_W      = MODE_W_DEF,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              de_in,
    input  logic              hs_in,
    input  logic              vs_in,
    output logic              de_o,
    output logic              hs_o,
    output logic              vs_o,
    output logic [X_W-1:0]    x_pos,
    output logic [Y_W-1:0]    y_pos,
    output logic              frame_start,
    output logic              line_start,
    input  logic [MODE_W-1:0] mode_req,
    input  logic              mode_req_valid,
    output logic              mode_req_ready,
    output logic [MODE_W-1:0] mode_active,
    output logic              mode_ack,
    output logic [X_W-1:0]    width_meas,
    output logic [Y_W-1:0]    height_meas,
    output logic              meas_valid,
    output logic              locked,
    output logic              timing_err
);

    localparam logic [X_W-1:0]    X_MAX  = '1;
    localparam logic [Y_W-1:0]    Y_MAX  = '1;
    localparam logic [LOCK_W-1:0] LOCK_N = LOCK_W'(LOCK_FRAMES);

    // bit 0: de (falling edge), bit 1: vs (rising edge)
    logic [1:0] sync_in, sync_q, sync_edge;
    assign sync_in = {vs_in, de_in};

    for (genvar i = 0; i < 2; i++) begin : g_edge
        vp_edge_det #(.FALL(i == 0)) u_edge (
            .clk    (clk),
            .rst    (rst),
            .d      (sync_in[i]),
            .q      (sync_q[i]),
            .edge_p (sync_edge[i])
        );
    end

    logic de_q, de_fall, vs_rise;
    assign de_q    = sync_q[0];
    assign de_fall = sync_edge[0];
    assign vs_rise = sync_edge[1];
    assign de_o    = de_q;
    assign vs_o    = sync_q[1];

    logic [X_W-1:0]    ref_w;
    logic [X_W-1:0]    line_len;
    logic              armed;
    logic [LOCK_W-1:0] stable;
    logic              lines_seen;
    logic              meas_same;

    // x_pos still holds the last pixel's column on the de-fall cycle
    assign line_len   = x_pos + X_W'(1);
    assign lines_seen = (y_pos != '0);
    assign meas_same  = meas_valid && (ref_w == width_meas) && (y_pos == height_meas);
    assign locked     = (stable == LOCK_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_o        <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            width_meas  <= '0;
            height_meas <= '0;
            meas_valid  <= 1'b0;
            timing_err  <= 1'b0;
            ref_w       <= '0;
            armed       <= 1'b0;
            stable      <= '0;
        end else begin
            hs_o        <= hs_in;
            frame_start <= vs_rise;
            line_start  <= de_in & ~de_q;

            if (de_in) begin
                if (!de_q)              x_pos <= '0;
                else if (x_pos != X_MAX) x_pos <= x_pos + X_W'(1);
            end

            if (vs_rise) begin
                // the frame just closed is only reported once a prior boundary armed us
                y_pos      <= '0;
                armed      <= 1'b1;
                timing_err <= de_in;
                if (armed && lines_seen) begin
                    width_meas  <= ref_w;
                    height_meas <= y_pos;
                    meas_valid  <= 1'b1;
                end
                if (armed && lines_seen && meas_same && !timing_err && !de_in)
                    stable <= sat_inc(stable, LOCK_N);
                else
                    stable <= '0;
            end else if (de_fall) begin
                if (y_pos != Y_MAX) y_pos <= y_pos + Y_W'(1);
                if (!lines_seen)              ref_w      <= line_len;
                else if (line_len != ref_w)   timing_err <= 1'b1;
            end
        end
    end

    mode_st_e          st, st_nxt;
    logic [MODE_W-1:0] pend, pend_nxt, active_nxt;
    logic              ack_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= MST_IDLE;
            pend        <= '0;
            mode_active <= MODE_W'(MODE_BYPASS);
            mode_ack    <= 1'b0;
        end else begin
            st          <= st_nxt;
            pend        <= pend_nxt;
            mode_active <= active_nxt;
            mode_ack    <= ack_nxt;
        end
    end

    // a request taken on a vs-rise cycle waits for the following boundary
    always_comb begin
        st_nxt         = st;
        pend_nxt       = pend;
        active_nxt     = mode_active;
        ack_nxt        = 1'b0;
        mode_req_ready = 1'b0;
        case (st)
            MST_IDLE: begin
                mode_req_ready = 1'b1;
                if (mode_req_valid) begin
                    pend_nxt = mode_req;
                    st_nxt   = MST_PEND;
                end
            end
            MST_PEND: begin
                if (vs_rise) begin
                    active_nxt = pend;
                    ack_nxt    = 1'b1;
                    st_nxt     = MST_IDLE;
                end
            end
            default: st_nxt = MST_IDLE;
        endcase
    end

endmodule
